// File: rtl/roulette_spin_ctrl.sv
// roulette_spin_ctrl
//   Palette-cycling animation controller for the roulette wheel sprite. A band
//   of CYC_LEN palette indices starting at CYC_BASE is rotated by a spin
//   offset. A start / decelerate / stop FSM advances the offset, paced by
//   the per-frame tick.
//
// Ports
//   Clk            in   system/pixel clock
//   Reset          in   synchronous, active-high
//   frame_tick     in   one-Clk pulse per video frame
//   start          in   spin request (honoured only in IDLE)
//   pix_index_in   in   4-bit palette index from the sprite ROM
//   pix_index_out  out  remapped palette index, registered (1 Clk latency)
//   busy           out  high while spinning
//   done           out  one-Clk pulse when the spin ends
//   result         out  current spin offset, stable whenever busy=0
module roulette_spin_ctrl #(
   parameter int CYC_BASE        = 11,
   parameter int CYC_LEN         = 4,
   parameter int INIT_DELAY      = 1,
   parameter int MAX_DELAY       = 8,
   parameter int STEPS_PER_DELAY = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_tick,
   input  logic                       start,
   input  logic [3:0]                 pix_index_in,
   output logic [3:0]                 pix_index_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(CYC_LEN)-1:0] result
);

   localparam int               OFF_W     = $clog2(CYC_LEN);
   localparam logic [3:0]       BASE4     = 4'(CYC_BASE);
   localparam logic [3:0]       MASK4     = 4'(CYC_LEN - 1);
   localparam logic [4:0]       BAND_END5 = 5'(CYC_BASE + CYC_LEN);
   localparam logic [3:0]       INIT_D4   = 4'(INIT_DELAY);
   localparam logic [3:0]       MAX_D4    = 4'(MAX_DELAY);
   localparam logic [4:0]       SPD5      = 5'(STEPS_PER_DELAY);
   localparam logic [OFF_W-1:0] OFF_ONE   = OFF_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SPIN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         free_cnt_q;
   logic [OFF_W-1:0]   offset_q, offset_d;
   logic [OFF_W-1:0]   extra_q, extra_d;
   logic [3:0]         delay_q, delay_d;
   logic [3:0]         wait_q, wait_d;
   logic [4:0]         step_q, step_d;
   logic [3:0]         pix_q;

   logic [4:0]         step_inc;
   logic [4:0]         quota;
   logic               last_level;
   logic               step_due;

   // Band-local rotation; the mask keeps the sum inside the band because
   // CYC_LEN is a power of two.
   function automatic logic [3:0] remap(input logic [3:0] idx, input logic [OFF_W-1:0] off);
      logic [3:0] rel;
      logic       in_band;
      rel     = (idx - BASE4 + 4'(off)) & MASK4;
      in_band = (idx >= BASE4) && ({1'b0, idx} < BAND_END5);
      remap   = in_band ? (BASE4 + rel) : idx;
   endfunction

   assign step_inc   = step_q + 5'd1;
   assign last_level = (delay_q == MAX_D4);
   // The random extra steps are only spent in the slowest level.
   assign quota      = last_level ? (SPD5 + 5'(extra_q)) : SPD5;
   assign step_due   = (wait_q == (delay_q - 4'd1));

   // State and counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         free_cnt_q <= 8'd0;
         offset_q   <= '0;
         extra_q    <= '0;
         delay_q    <= 4'd0;
         wait_q     <= 4'd0;
         step_q     <= 5'd0;
         pix_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         free_cnt_q <= free_cnt_q + 8'd1;
         offset_q   <= offset_d;
         extra_q    <= extra_d;
         delay_q    <= delay_d;
         wait_q     <= wait_d;
         step_q     <= step_d;
         pix_q      <= remap(pix_index_in, offset_q);
      end
   end

   // Next-state and counter update
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      extra_d  = extra_q;
      delay_d  = delay_q;
      wait_d   = wait_q;
      step_d   = step_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SPIN;
               delay_d = INIT_D4;
               wait_d  = 4'd0;
               step_d  = 5'd0;
               extra_d = free_cnt_q[OFF_W-1:0];
            end
         end
         S_SPIN: begin
            if (frame_tick) begin
               if (step_due) begin
                  wait_d   = 4'd0;
                  offset_d = offset_q + OFF_ONE;
                  if (step_inc == quota) begin
                     step_d = 5'd0;
                     if (last_level) begin
                        state_d = S_DONE;
                     end else begin
                        delay_d = delay_q + 4'd1;
                     end
                  end else begin
                     step_d = step_inc;
                  end
               end else begin
                  wait_d = wait_q + 4'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_SPIN:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign result        = offset_q;
   assign pix_index_out = pix_q;

endmodule

// File: tb/tb_roulette_spin_ctrl.sv
module tb_roulette_spin_ctrl;

   logic       Clk;
   logic       Reset;
   logic       frame_tick;
   logic       start;
   logic [3:0] pix_in;
   logic [3:0] pix_out;
   logic       busy;
   logic       done;
   logic [1:0] result;

   logic       start2;
   logic       tick2;
   logic [3:0] pix_in2;
   logic [3:0] pix_out2;
   logic       busy2;
   logic       done2;
   logic [0:0] result2;

   int         checks;
   int         errors;
   logic [7:0] fc;      // bench copy of the free-running counter
   int         exp_off; // offset the wheel is expected to rest at

   typedef struct {
      int steps;
      int ticks;
      int res;
   } spin_exp_t;

   spin_exp_t spin_q[$];
   int        pix_q[$];

   roulette_spin_ctrl dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_tick   (frame_tick),
      .start        (start),
      .pix_index_in (pix_in),
      .pix_index_out(pix_out),
      .busy         (busy),
      .done         (done),
      .result       (result)
   );

   roulette_spin_ctrl #(
      .CYC_BASE       (11),
      .CYC_LEN        (2),
      .INIT_DELAY     (1),
      .MAX_DELAY      (1),
      .STEPS_PER_DELAY(1)
   ) dut2 (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_tick   (tick2),
      .start        (start2),
      .pix_index_in (pix_in2),
      .pix_index_out(pix_out2),
      .busy         (busy2),
      .done         (done2),
      .result       (result2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) fc <= Reset ? 8'd0 : fc + 8'd1;

   function automatic int model_remap(input int idx, input int off);
      if (idx >= 11 && idx <= 14) return 11 + ((idx - 11 + off) % 4);
      return idx;
   endfunction

   task automatic wait_fc(input logic [7:0] mask, input logic [7:0] val);
      int n;
      n = 0;
      while (((fc & mask) != val) && n < 300) begin
         @(posedge Clk); #1;
         n++;
      end
      checks++;
      if ((fc & mask) != val) begin
         errors++;
         $display("FAIL wait_fc counter=%0h required %0h", fc & mask, val);
      end
   endtask

   // Drives ticks every 10 Clk (starting in the start cycle) and observes one spin.
   // mode 0: quiet, mode 1: start pulses while busy, mode 2: start held high.
   task automatic spin_measure(input int mode, output int ticks, output int steps,
                               output int dones, output int busy_cyc, output int last_tick,
                               output int done_cyc, output logic busy_a1,
                               output logic busy_a2, output logic timed_out);
      int         cyc;
      logic       prev_busy;
      logic       prev_tick;
      logic [1:0] prev_res;
      ticks = 0; steps = 0; dones = 0; busy_cyc = 0; last_tick = 0;
      done_cyc = -1; busy_a1 = 1'b0; busy_a2 = 1'b0; timed_out = 1'b0;
      cyc = 0;
      frame_tick = 1'b1;
      prev_busy = busy;
      prev_tick = 1'b1;
      prev_res  = result;
      while (1) begin
         @(posedge Clk); #1;
         cyc++;
         if (prev_busy && prev_tick) begin
            ticks++;
            last_tick = cyc - 1;
         end
         if (result != prev_res) steps++;
         if (busy && done_cyc < 0) busy_cyc++;
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_a1 = busy;
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            busy_a2 = busy;
            break;
         end
         if (cyc > 2500) begin
            timed_out = 1'b1;
            break;
         end
         prev_busy  = busy;
         prev_res   = result;
         frame_tick = (done_cyc < 0) && (cyc % 10 == 0);
         case (mode)
            1:       start = (done_cyc < 0) && (frame_tick || (cyc % 7 == 3));
            2:       start = 1'b1;
            default: start = 1'b0;
         endcase
         prev_tick = frame_tick;
      end
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      Reset  = 1'b1;
      pix_in = 4'd7;
      repeat (3) @(posedge Clk);
      #1;
      checks++; if (pix_out !== 4'd0) begin errors++; $display("FAIL reset_pix got %0d exp 0", pix_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (result !== 2'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
      checks++; if (busy2 !== 1'b0 || result2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 busy=%b result=%0d exp 0 0", busy2, result2); end
      Reset   = 1'b0;
      exp_off = 0;
   endtask

   task automatic test_remap_sweep(input int off);
      int e;
      for (int i = 0; i < 16; i++) begin
         pix_in = 4'(i);
         pix_q.push_back(model_remap(i, off));
         @(posedge Clk); #1;
         e = pix_q.pop_front();
         checks++;
         if (pix_out !== 4'(e)) begin
            errors++;
            $display("FAIL remap_sweep off=%0d in=%0d got %0d exp %0d", off, i, pix_out, e);
         end
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 2'(off)) begin
         errors++;
         $display("FAIL sweep_status busy=%b done=%b result=%0d exp 0 0 %0d", busy, done, result, off);
      end
   endtask

   task automatic test_remap_table();
      int ins[6];
      int exps[6];
      int e;
      ins  = '{10, 11, 12, 13, 14, 15};
      exps = '{10, 14, 11, 12, 13, 15};
      for (int i = 0; i < 6; i++) begin
         pix_in = 4'(ins[i]);
         pix_q.push_back(exps[i]);
         @(posedge Clk); #1;
         e = pix_q.pop_front();
         checks++;
         if (pix_out !== 4'(e)) begin
            errors++;
            $display("FAIL remap_table in=%0d got %0d exp %0d", ins[i], pix_out, e);
         end
      end
   endtask

   task automatic test_spin(input string name, input int mode, input logic [7:0] mask,
                            input logic [7:0] val);
      spin_exp_t e;
      int        ext;
      int        ticks, steps, dones, busy_cyc, last_tick, done_cyc;
      logic      busy_a1, busy_a2, timed_out;
      wait_fc(mask, val);
      ext     = int'(fc & 8'h03);
      e.steps = 32 + ext;
      e.ticks = 144 + 8 * ext;
      e.res   = (exp_off + e.steps) % 4;
      spin_q.push_back(e);
      start = 1'b1;
      spin_measure(mode, ticks, steps, dones, busy_cyc, last_tick, done_cyc,
                   busy_a1, busy_a2, timed_out);
      start = 1'b0;
      e = spin_q.pop_front();
      checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout done not seen within budget", name); end
      checks++; if (ticks != e.ticks) begin errors++; $display("FAIL %s_ticks got %0d exp %0d", name, ticks, e.ticks); end
      checks++; if (steps != e.steps) begin errors++; $display("FAIL %s_steps got %0d exp %0d", name, steps, e.steps); end
      checks++; if (result !== 2'(e.res)) begin errors++; $display("FAIL %s_result got %0d exp %0d", name, result, e.res); end
      checks++; if (dones != 1) begin errors++; $display("FAIL %s_done_count got %0d exp 1", name, dones); end
      checks++; if (done_cyc != last_tick + 1) begin errors++; $display("FAIL %s_done_timing got cycle %0d exp %0d", name, done_cyc, last_tick + 1); end
      checks++; if (busy_cyc != last_tick) begin errors++; $display("FAIL %s_busy_span got %0d exp %0d", name, busy_cyc, last_tick); end
      checks++; if (busy_a1 !== 1'b0) begin errors++; $display("FAIL %s_busy_after_done got %b exp 0", name, busy_a1); end
      checks++;
      if (busy_a2 !== (mode == 2)) begin
         errors++;
         $display("FAIL %s_restart got busy %b exp %b", name, busy_a2, (mode == 2));
      end
      exp_off = e.res;
   endtask

   task automatic test_reset_mid_spin();
      int   cyc;
      int   tk;
      int   dn;
      int   bz;
      logic hit;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset  = 1'b0;
      pix_in = 4'd12;
      start  = 1'b1;
      frame_tick = 1'b0;
      cyc = 0; tk = 0; hit = 1'b0;
      while (cyc < 1000) begin
         @(posedge Clk); #1;
         cyc++;
         start = 1'b0;
         if (Reset) begin
            hit = 1'b1;
            break;
         end
         frame_tick = (cyc % 10 == 0);
         if (frame_tick && busy) tk++;
         if (frame_tick && tk == 50) Reset = 1'b1;
      end
      Reset      = 1'b0;
      frame_tick = 1'b0;
      checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach ticks got %0d exp 50", tk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      checks++; if (result !== 2'd0) begin errors++; $display("FAIL rst_mid_result got %0d exp 0", result); end
      checks++; if (pix_out !== 4'd0) begin errors++; $display("FAIL rst_mid_pix got %0d exp 0", pix_out); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
      dn = 0; bz = 0;
      for (int i = 1; i <= 40; i++) begin
         frame_tick = (i % 10 == 0);
         @(posedge Clk); #1;
         if (done) dn++;
         if (busy) bz++;
      end
      frame_tick = 1'b0;
      checks++; if (dn != 0 || bz != 0) begin errors++; $display("FAIL rst_mid_after done=%0d busy=%0d exp 0 0", dn, bz); end
      exp_off = 0;
   endtask

   task automatic test_small_params();
      logic [0:0] r0;
      wait_fc(8'h01, 8'h01);
      r0     = result2;
      start2 = 1'b1;
      @(posedge Clk); #1;
      start2 = 1'b0;
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL small_busy_rise got %b exp 1", busy2); end
      @(posedge Clk); #1;
      tick2 = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (result2 !== ~r0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL small_step1 result=%0d busy=%b done=%b exp %0d 1 0", result2, busy2, done2, ~r0);
      end
      @(posedge Clk); #1;
      tick2 = 1'b0;
      checks++;
      if (result2 !== r0 || busy2 !== 1'b0 || done2 !== 1'b1) begin
         errors++;
         $display("FAIL small_step2 result=%0d busy=%b done=%b exp %0d 0 1", result2, busy2, done2, r0);
      end
      @(posedge Clk); #1;
      checks++;
      if (done2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL small_after done=%b busy=%b exp 0 0", done2, busy2);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      Reset      = 1'b1;
      start      = 1'b0;
      frame_tick = 1'b0;
      pix_in     = 4'd0;
      start2     = 1'b0;
      tick2      = 1'b0;
      pix_in2    = 4'd0;
      exp_off    = 0;

      test_reset();
      test_remap_sweep(0);
      test_spin("basic", 0, 8'hFF, 8'h20);
      test_spin("extra3", 0, 8'h03, 8'h03);
      test_remap_table();
      test_remap_sweep(exp_off);
      test_spin("mid_start", 1, 8'h03, 8'h01);
      test_spin("start_held", 2, 8'h03, 8'h02);
      test_reset_mid_spin();
      test_small_params();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/roulette_spin_ctrl.md
# roulette_spin_ctrl

Animation controller for the roulette wheel sprite. It sits between the sprite ROM's 4-bit palette-index output and the 16-entry roulette palette lookup. It animates the wheel by palette cycling: a contiguous band of indices is rotated by a spin offset. The offset is advanced by a start / decelerate / stop state machine that is paced by the per-frame tick. It reports busy, a one-cycle done pulse, and the resting offset as the spin result.

## Interface
- CYC_BASE, default 11: first palette index of the rotating band.
- CYC_LEN, default 4: band length. Must be 2, 4 or 8, and CYC_BASE+CYC_LEN ≤ 16.
- INIT_DELAY, default 1: frame ticks per step when the spin starts (≥1).
- MAX_DELAY, default 8: frame ticks per step in the final phase (≥ INIT_DELAY, ≤ 15).
- STEPS_PER_DELAY, default 4: steps taken at each delay level (≥1, ≤ 15).

Ports:
- Clk  in  1  system/pixel clock; the only clock.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-Clk pulse per video frame (vsync-derived).
- start  in  1  spin request, sampled every Clk.
- pix_index_in  in  4  palette index from the sprite ROM.
- pix_index_out  out  4  remapped index to the palette, registered.
- busy  out  1  high while in SPIN.
- done  out  1  one-Clk pulse when the spin ends.
- result  out  CLOG2(CYC_LEN)  current spin offset; stable whenever busy=0.

## Operation
- State: free_cnt (8 b, +1 every Clk, wraps), offset, delay (4 b), wait_cnt (4 b), step_cnt (5 b), extra.
- FSM states and transitions:
  - IDLE, on start=1 → SPIN. Load delay=INIT_DELAY, wait_cnt=0, step_cnt=0, extra=free_cnt & (CYC_LEN-1).
  - SPIN, on each frame_tick:
    - If wait_cnt == delay-1: set wait_cnt=0, offset=(offset+1) mod CYC_LEN, step_cnt += 1.
    - Otherwise: wait_cnt += 1.
  - SPIN, level end: a level ends when the step just taken makes step_cnt equal to the level's step quota.
    - Quota is STEPS_PER_DELAY, or STEPS_PER_DELAY+extra when delay==MAX_DELAY.
    - At level end: step_cnt=0. If delay==MAX_DELAY → DONE, otherwise delay += 1.
  - DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- start is ignored in SPIN and DONE. frame_tick is ignored in IDLE and DONE.
- offset persists through IDLE, so the wheel rests where it stopped. The next spin continues from it.
- Totals:
  - Steps per spin = (MAX_DELAY-INIT_DELAY+1)·STEPS_PER_DELAY + extra.
  - Final offset = (start offset + total steps) mod CYC_LEN.
  - SPIN length in ticks = STEPS_PER_DELAY·Σ(d, d=INIT_DELAY..MAX_DELAY) + MAX_DELAY·extra.
- Remap, registered every Clk regardless of state:
  - If CYC_BASE ≤ pix_index_in < CYC_BASE+CYC_LEN: pix_index_out = CYC_BASE + ((pix_index_in-CYC_BASE+offset) & (CYC_LEN-1)).
  - Otherwise: pix_index_out = pix_index_in.
  - All arithmetic is 4-bit; no result leaves the band.
- Reset values: pix_index_out=0, busy=0, done=0, result/offset=0, free_cnt=0, state IDLE, all counters 0.

## Timing
- pix_index_out latency is 1 Clk from pix_index_in. The consumer delays pixel coordinates to match.
- An offset step made on the tick edge is visible in pix_index_out for inputs sampled on the next edge. One mixed frame is acceptable; the band is normally off-screen during vsync.
- busy rises on the edge after start is sampled in IDLE.
- busy falls on the edge after the final step's tick. done is high for that one cycle. result is already final in that cycle.
- A new start can be accepted no earlier than the cycle after DONE, i.e. on the edge where the state is IDLE.
- start and frame_tick in the same IDLE cycle: the start is accepted and the tick is not counted.
- Reset asserted mid-spin: on the next edge everything returns to reset values, including offset=0 and no done pulse.
- start held high continuously: a new spin begins on the first IDLE cycle after each DONE.

## Test plan
- Reset, then pix_index_in sweeps 0..15 with offset 0 → pix_index_out equals input one Clk later. busy=0, done=0, result=0.
- Start with free_cnt=0x20 (extra=0), frame_tick every 10 Clk, defaults:
  - 32 steps in 144 ticks.
  - done pulses once, one Clk after the 144th tick.
  - result=0, and busy is high for exactly that span.
- Start with free_cnt & 3 = 3, initial offset 0:
  - 35 steps in 168 ticks; result=3.
  - Afterwards inputs 11,12,13,14 map to 14,11,12,13; inputs 10 and 15 pass unchanged.
- Mid-spin, start pulses and frame_tick coincides with a start while busy → no restart and no change to the step count. The next start is accepted only after done.
- Reset asserted at tick 50 of a spin → the next Clk shows busy=0, result=0, pix_index_out=0. No done pulse follows.
- INIT_DELAY=MAX_DELAY=1, STEPS_PER_DELAY=1, CYC_LEN=2, extra=1 → 2 steps on 2 consecutive ticks, result returns to its start value, done follows the second tick.
